// File: rtl/ysyx_23060240_bus_pkg.sv
// Shared bus-arbitration types: FSM states, master ownership encoding and
// timer sizing for the IFU/LSU memory arbiter.
package ysyx_23060240_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  // Encoding doubles as the bit index into the arbiter's request/grant vectors.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam int DEF_TIMEOUT = 1024;

  function automatic int timer_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ysyx_23060240_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins outright, a tie goes to
// whichever master was not granted last.
module ysyx_23060240_rr_arb2
  import ysyx_23060240_bus_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Shares the single data-memory port between IFU and LSU: one outstanding
// transaction, round-robin on ties, synthesised error response on timeout.
module ysyx_23060240_mem_arbiter
  import ysyx_23060240_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                lsu_rsp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_err,

  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int TMR_W  = timer_w(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  state_e              state;
  owner_e              owner, last_grant;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                err_q;
  logic [TMR_W-1:0]    timer, timer_inc;
  logic [1:0]          grant;
  logic                idle, accept, tmo, owner_rsp_ready;

  ysyx_23060240_rr_arb2 u_arb (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle            = (state == ST_IDLE);
  assign accept          = idle && (ifu_req_valid || lsu_req_valid);
  assign timer_inc       = (timer == '1) ? timer : timer + TMR_W'(1);
  // >= rather than == so a timer that saturates past the limit still expires.
  assign tmo             = (TIMEOUT != 0) && (timer >= TMR_LAST);
  assign owner_rsp_ready = (owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

  assign ifu_req_ready = idle && grant[0];
  assign lsu_req_ready = idle && grant[1];
  assign mem_req_valid = (state == ST_REQ);
  assign mem_rsp_ready = idle || (state == ST_WAIT);
  assign busy          = !idle;

  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  assign ifu_rsp_valid = (state == ST_RSP) && (owner == OWN_IFU);
  assign lsu_rsp_valid = (state == ST_RSP) && (owner == OWN_LSU);
  assign ifu_rsp_data  = rdata_q;
  assign lsu_rsp_data  = rdata_q;
  assign ifu_rsp_err   = err_q;
  assign lsu_rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      timer      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          timer <= '0;
          state <= ST_REQ;
          if (grant[1]) begin
            owner   <= OWN_LSU;
            addr_q  <= lsu_req_addr;
            wen_q   <= lsu_req_wen;
            wdata_q <= lsu_req_wdata;
            wmask_q <= lsu_req_wmask;
          end else begin
            owner   <= OWN_IFU;
            addr_q  <= ifu_req_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '1;
          end
        end
        ST_REQ: begin
          timer <= timer_inc;
          if (mem_req_ready) begin
            state <= ST_WAIT;
          end else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RSP;
          end
        end
        ST_WAIT: begin
          timer <= timer_inc;
          // A real response in the expiry cycle takes priority over the timeout.
          if (mem_rsp_valid) begin
            rdata_q <= wen_q ? '0 : mem_rsp_data;
            err_q   <= mem_rsp_err;
            state   <= ST_RSP;
          end else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RSP;
          end
        end
        ST_RSP: if (owner_rsp_ready) begin
          last_grant <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: per-address memory model,
// expected responses queued at request acceptance, monitor checks on handshake.
module tb_ysyx_23060240_mem_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic [3:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wmask;
  logic        busy;

  ysyx_23060240_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
    .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic err; logic [31:0] data; } rsp_t;
  typedef struct { int r; int d; logic [31:0] data; logic err; } plan_t;

  int          n_chk = 0, n_fail = 0;
  rsp_t        exp_ifu[$], exp_lsu[$];
  logic        last_owner;
  int          ifu_rdy_mode = 1, lsu_rdy_mode = 1;
  logic        mem_busy;
  logic        hold_v[2];
  logic [32:0] hold_d[2];
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_wen;
  logic [3:0]  seen_wmask;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory behaviour per address: r = cycles request-ready is withheld,
  // d = cycles from request handshake to the one-cycle response pulse.
  function automatic plan_t mem_plan(input logic [31:0] a);
    plan_t p;
    p.r = int'(a[3:2]);
    p.d = (int'(a[6:4]) + 2) % 6;
    p.data = a ^ 32'h5a5a_1234;
    p.err = (a[9:7] == 3'b111);
    case (a)
      32'h8000_0000: begin p.r = 0; p.d = 2; p.data = 32'h0000_0413; p.err = 1'b0; end
      32'h8000_1000: begin p.r = 5; p.d = 0; end
      32'h8000_2000: begin p.r = 0; p.d = 20; end
      32'h8000_3000: begin p.err = 1'b1; end
      32'h8000_4000: begin p.r = 0; p.d = 5; end
      default: ;
    endcase
    return p;
  endfunction

  // The memory answers on cycle r+d+2 of the REQ/WAIT window; later than TMO -> timeout.
  function automatic rsp_t expect_rsp(input logic [31:0] a, input logic wen);
    plan_t p;
    rsp_t  e;
    p = mem_plan(a);
    if (p.r + p.d + 2 > TMO) begin
      e.data = 32'h0; e.err = 1'b1;
    end else begin
      e.data = wen ? 32'h0 : p.data; e.err = p.err;
    end
    return e;
  endfunction

  function automatic logic rdy(input int mode);
    if (mode == 2) return ($urandom_range(0, 99) < 60);
    return (mode == 1);
  endfunction

  initial begin
    ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ifu_rsp_ready = rdy(ifu_rdy_mode);
      lsu_rsp_ready = rdy(lsu_rdy_mode);
    end
  end

  // Memory model
  initial begin
    plan_t p;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0; mem_busy = 0;
    @(negedge clk);
    forever begin
      while (!(mem_req_valid && rst)) @(negedge clk);
      mem_busy = 1;
      seen_addr = mem_req_addr; seen_wen = mem_req_wen;
      seen_wdata = mem_req_wdata; seen_wmask = mem_req_wmask;
      p = mem_plan(mem_req_addr);
      for (int k = 0; k < p.r; k++) begin
        @(negedge clk);
        check("mem_req_hold_addr", {mem_req_valid, mem_req_addr}, {1'b1, seen_addr});
        check("mem_req_hold_data", {mem_req_wen, mem_req_wmask, mem_req_wdata},
              {seen_wen, seen_wmask, seen_wdata});
      end
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      repeat (p.d) @(negedge clk);
      mem_rsp_valid = 1; mem_rsp_data = p.data; mem_rsp_err = p.err;
      @(negedge clk);
      mem_rsp_valid = 0; mem_busy = 0;
    end
  end

  task automatic mon_rsp(input int m, input string name, input logic v, input logic r,
                         input logic [32:0] de);
    rsp_t e;
    if (hold_v[m]) check({name, "_hold"}, {v, de}, {1'b1, hold_d[m]});
    hold_v[m] = v && !r;
    hold_d[m] = de;
    if (v && r) begin
      if ((m == 0 && exp_ifu.size() == 0) || (m == 1 && exp_lsu.size() == 0)) begin
        n_chk++; n_fail++;
        $display("FAIL %s_unexpected: got rsp %0h expected no response", name, de);
      end else begin
        if (m == 0) e = exp_ifu.pop_front();
        else        e = exp_lsu.pop_front();
        check({name, "_rsp"}, de, e);
      end
      last_owner = m[0];
    end
  endtask

  // Monitor: arbitration model plus response scoreboard
  initial begin
    logic ei, el;
    last_owner = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_v[0] = 0; hold_v[1] = 0; last_owner = 0;
      end else begin
        if (busy) begin
          check("ready_while_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
        end else begin
          ei = ifu_req_valid && (!lsu_req_valid || last_owner);
          el = lsu_req_valid && (!ifu_req_valid || !last_owner);
          check("arb_grant", {ifu_req_ready, lsu_req_ready}, {ei, el});
        end
        mon_rsp(0, "ifu", ifu_rsp_valid, ifu_rsp_ready, {ifu_rsp_err, ifu_rsp_data});
        mon_rsp(1, "lsu", lsu_rsp_valid, lsu_rsp_ready, {lsu_rsp_err, lsu_rsp_data});
      end
    end
  end

  task automatic ifu_issue(input logic [31:0] a, output int acc);
    int k;
    ifu_req_valid = 1; ifu_req_addr = a; acc = -1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ifu_req_ready) break;
    end
    if (k == 300) check("ifu_req_accept_timeout", 0, 1);
    else begin acc = cyc; exp_ifu.push_back(expect_rsp(a, 1'b0)); end
    @(posedge clk); #1;
    ifu_req_valid = 0;
  endtask

  task automatic lsu_issue(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                           input logic [3:0] wm, output int acc);
    int k;
    lsu_req_valid = 1; lsu_req_addr = a; lsu_req_wen = wen;
    lsu_req_wdata = wd; lsu_req_wmask = wm; acc = -1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (lsu_req_ready) break;
    end
    if (k == 300) check("lsu_req_accept_timeout", 0, 1);
    else begin acc = cyc; exp_lsu.push_back(expect_rsp(a, wen)); end
    @(posedge clk); #1;
    lsu_req_valid = 0;
  endtask

  task automatic wait_rsp(input int m, output int c);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m == 0 ? ifu_rsp_valid : lsu_rsp_valid) break;
    end
    if (k == 100) check("rsp_valid_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy && !mem_busy) break;
    end
    if (k == 200) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                            mem_req_valid, mem_rsp_ready, busy}, 7'b0000010);
    check({tag, "_payload"}, {mem_req_addr, mem_req_wen, mem_req_wmask}, 0);
    check({tag, "_rspdata"}, {ifu_rsp_err, ifu_rsp_data}, 0);
  endtask

  initial begin
    int a0, a1, c;
    logic [31:0] t;
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1;
    @(posedge clk); #1;

    // IFU fetch with 2-cycle memory response
    ifu_issue(32'h8000_0000, a0);
    wait_rsp(0, c);
    check("ifu_fetch_latency", c - a0, 5);
    wait_idle();

    // Tie after an IFU grant goes to LSU; IFU follows
    fork
      ifu_issue(32'h8000_0010, a0);
      lsu_issue(32'h8000_0020, 1'b0, 32'h0, 4'hf, a1);
    join
    check("tie_lsu_first", a1 < a0, 1);
    wait_idle();
    lsu_issue(32'h8000_0030, 1'b0, 32'h0, 4'hf, a1);
    wait_idle();
    fork
      ifu_issue(32'h8000_0050, a0);
      lsu_issue(32'h8000_0060, 1'b0, 32'h0, 4'hf, a1);
    join
    check("tie_ifu_next", a0 < a1, 1);
    wait_idle();

    // Store with request-ready withheld 5 cycles
    lsu_issue(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3, a1);
    wait_idle();
    check("store_payload", {seen_addr, seen_wen, seen_wmask}, {32'h8000_1000, 1'b1, 4'h3});
    check("store_wdata", seen_wdata, 32'hDEAD_BEEF);

    // Memory never answers in time; the late pulse lands in IDLE
    ifu_issue(32'h8000_2000, a0);
    wait_rsp(0, c);
    check("timeout_latency", c - a0, 1 + TMO);
    wait_idle();

    // LSU owner holds rsp_ready low while IFU is waiting; error propagates
    lsu_rdy_mode = 0;
    fork
      begin
        lsu_issue(32'h8000_3000, 1'b0, 32'h0, 4'hf, a1);
        wait_rsp(1, c);
        repeat (3) @(posedge clk);
        #1 lsu_rdy_mode = 1;
      end
      begin
        @(posedge clk); #1;
        ifu_issue(32'h8000_0040, a0);
      end
    join
    check("held_ifu_after_lsu", a0 > a1 + 3, 1);
    wait_idle();

    // Async reset in WAIT abandons the transaction
    ifu_issue(32'h8000_4000, a0);
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (busy && mem_rsp_ready) break;
    end
    check("reached_wait", busy && mem_rsp_ready, 1);
    #2 rst = 0;
    #1 check_reset_outputs("async_reset");
    exp_ifu.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    wait_idle();
    ifu_issue(32'h8000_0000, a0);
    wait_idle();

    // Randomised traffic from both masters with random response back-pressure
    ifu_rdy_mode = 2; lsu_rdy_mode = 2;
    fork
      repeat (30) begin
        int acc;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        t = $urandom();
        ifu_issue({4'hA, t[27:0]}, acc);
      end
      repeat (30) begin
        int acc;
        logic [31:0] u;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        u = $urandom();
        lsu_issue({4'hA, u[27:0]}, 1'($urandom_range(0, 1)), $urandom(),
                  4'($urandom_range(0, 15)), acc);
      end
    join
    ifu_rdy_mode = 1; lsu_rdy_mode = 1;
    wait_idle();
    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_ifu.size() + exp_lsu.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
